// File: rtl/sc_game_pkg.sv
// rtl/sc_game_pkg.sv - shared level, state, period and score-threshold definitions for the game timer
package sc_game_pkg;

  typedef enum logic [1:0] {
    LVL_STOP = 2'd0,
    LVL_1    = 2'd1,
    LVL_2    = 2'd2,
    LVL_3    = 2'd3
  } level_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam int DEF_PRESCALE_MAX = 49999;
  localparam int DEF_PERIOD_WIDTH = 12;
  localparam int DEF_LVL1_PERIOD  = 500;
  localparam int DEF_LVL2_PERIOD  = 350;
  localparam int DEF_LVL3_PERIOD  = 200;
  localparam int DEF_POINT_WIDTH  = 8;

  // Score levels at which the downstream state machine raises difficulty
  localparam int PTS_THRESH_1 = 32;
  localparam int PTS_THRESH_2 = 64;
  localparam int PTS_THRESH_3 = 128;

endpackage

// File: rtl/sc_tick_prescaler.sv
// rtl/sc_tick_prescaler.sv - free-running base-tick prescaler with enable and synchronous clear
module sc_tick_prescaler
  import sc_game_pkg::*;
#(
  parameter int PRESCALE_MAX = DEF_PRESCALE_MAX
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CW = (PRESCALE_MAX > 0) ? $clog2(PRESCALE_MAX + 1) : 1;
  localparam logic [CW-1:0] TERM = CW'(PRESCALE_MAX);

  logic [CW-1:0] cnt_q, cnt_d;

  // A clear in the same cycle swallows the tick so no strobe leaks out of a reset period
  assign tick_o = en_i && !clr_i && (cnt_q == TERM);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (tick_o) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sc_game_timer_score.sv
// rtl/sc_game_timer_score.sv - level-dependent movement/speed strobes and saturating score counter
module sc_game_timer_score
  import sc_game_pkg::*;
#(
  parameter int PRESCALE_MAX = DEF_PRESCALE_MAX,
  parameter int PERIOD_WIDTH = DEF_PERIOD_WIDTH,
  parameter int LVL1_PERIOD  = DEF_LVL1_PERIOD,
  parameter int LVL2_PERIOD  = DEF_LVL2_PERIOD,
  parameter int LVL3_PERIOD  = DEF_LVL3_PERIOD,
  parameter int POINT_WIDTH  = DEF_POINT_WIDTH
) (
  input  logic                   SC_GAMETIMER_CLOCK_50,
  input  logic                   SC_GAMETIMER_RESET_InLow,
  input  logic                   SC_GAMETIMER_clear_InLow,
  input  logic [1:0]             SC_GAMETIMER_level_InBUS,
  input  logic                   SC_GAMETIMER_hold_InLow,
  input  logic                   SC_GAMETIMER_move_InLow,
  output logic                   SC_GAMETIMER_timer_OutLow,
  output logic                   SC_GAMETIMER_speedComparator_OutLow,
  output logic [POINT_WIDTH-1:0] SC_GAMETIMER_pointCounter_OutBUS
);

  localparam logic [PERIOD_WIDTH-1:0] P1 = PERIOD_WIDTH'(LVL1_PERIOD);
  localparam logic [PERIOD_WIDTH-1:0] P2 = PERIOD_WIDTH'(LVL2_PERIOD);
  localparam logic [PERIOD_WIDTH-1:0] P3 = PERIOD_WIDTH'(LVL3_PERIOD);

  state_e                  state_q, state_d;
  level_e                  level_q, level_in;
  logic [PERIOD_WIDTH-1:0] period_cnt_q, period_cnt_d, period;
  logic [POINT_WIDTH-1:0]  points_q, points_d;
  logic                    timer_q, timer_d, speed_q, speed_d;
  logic                    clear, lvl_chg, cnt_clr, tick, period_end, mid_hit;

  assign level_in = level_e'(SC_GAMETIMER_level_InBUS);
  assign clear    = !SC_GAMETIMER_clear_InLow;

  always_comb begin
    state_d = RUN;
    if (level_in == LVL_STOP) begin
      state_d = IDLE;
    end else if (!SC_GAMETIMER_hold_InLow) begin
      state_d = HOLD;
    end
  end

  // Coming out of IDLE is not a level change: counters are already zero there
  assign lvl_chg = (state_q != IDLE) && (level_in != LVL_STOP) && (level_in != level_q);
  assign cnt_clr = clear || (state_d == IDLE) || lvl_chg;

  sc_tick_prescaler #(
    .PRESCALE_MAX(PRESCALE_MAX)
  ) u_prescaler (
    .clk_i (SC_GAMETIMER_CLOCK_50),
    .rst_ni(SC_GAMETIMER_RESET_InLow),
    .en_i  (state_d == RUN),
    .clr_i (cnt_clr),
    .tick_o(tick)
  );

  always_comb begin
    case (level_in)
      LVL_2:   period = P2;
      LVL_3:   period = P3;
      default: period = P1;
    endcase
  end

  assign period_end = tick && (period_cnt_q == period - 1'b1);
  assign mid_hit    = tick && (period[PERIOD_WIDTH-1:1] != '0)
                      && (period_cnt_q == (period >> 1) - 1'b1);

  always_comb begin
    period_cnt_d = period_cnt_q;
    if (cnt_clr || period_end) begin
      period_cnt_d = '0;
    end else if (tick) begin
      period_cnt_d = period_cnt_q + 1'b1;
    end
  end

  assign timer_d = !period_end;
  assign speed_d = !mid_hit;

  always_comb begin
    points_d = points_q;
    if (clear) begin
      points_d = '0;
    end else if ((state_d != IDLE) && !SC_GAMETIMER_move_InLow && (points_q != '1)) begin
      points_d = points_q + 1'b1;
    end
  end

  always_ff @(posedge SC_GAMETIMER_CLOCK_50 or negedge SC_GAMETIMER_RESET_InLow) begin
    if (!SC_GAMETIMER_RESET_InLow) begin
      state_q      <= IDLE;
      level_q      <= LVL_STOP;
      period_cnt_q <= '0;
      points_q     <= '0;
      timer_q      <= 1'b1;
      speed_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      level_q      <= level_in;
      period_cnt_q <= period_cnt_d;
      points_q     <= points_d;
      timer_q      <= timer_d;
      speed_q      <= speed_d;
    end
  end

  assign SC_GAMETIMER_timer_OutLow           = timer_q;
  assign SC_GAMETIMER_speedComparator_OutLow = speed_q;
  assign SC_GAMETIMER_pointCounter_OutBUS    = points_q;

endmodule

// File: tb/tb_sc_game_timer_score.sv
// tb/tb_sc_game_timer_score.sv - directed bench with elapsed-time reference model for sc_game_timer_score
module tb_sc_game_timer_score;

  localparam int Q = 4;  // clocks per base tick (PRESCALE_MAX=3)

  logic       clk = 1'b0;
  logic       rst_n, clear_n, hold_n, move_n;
  logic [1:0] level;
  logic       timer_o, speed_o;
  logic [7:0] pts_o;

  int n_chk = 0, n_fail = 0;
  int m_e, m_pts, m_prev, exp_t, exp_s;
  bit chk_en = 1'b0;
  int lows;

  always #5 clk = ~clk;

  sc_game_timer_score #(
    .PRESCALE_MAX(3), .PERIOD_WIDTH(12),
    .LVL1_PERIOD(5), .LVL2_PERIOD(3), .LVL3_PERIOD(2), .POINT_WIDTH(8)
  ) dut (
    .SC_GAMETIMER_CLOCK_50              (clk),
    .SC_GAMETIMER_RESET_InLow           (rst_n),
    .SC_GAMETIMER_clear_InLow           (clear_n),
    .SC_GAMETIMER_level_InBUS           (level),
    .SC_GAMETIMER_hold_InLow            (hold_n),
    .SC_GAMETIMER_move_InLow            (move_n),
    .SC_GAMETIMER_timer_OutLow          (timer_o),
    .SC_GAMETIMER_speedComparator_OutLow(speed_o),
    .SC_GAMETIMER_pointCounter_OutBUS   (pts_o)
  );

  function automatic int per(input int l);
    case (l)
      1:       return 5;
      2:       return 3;
      3:       return 2;
      default: return 0;
    endcase
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_e = 0; m_pts = 0; m_prev = 0; exp_t = 1; exp_s = 1;
  endtask

  // Model tracks elapsed running clocks since the period started, not prescaler/period counts
  task automatic model_update();
    int l, p;
    l = int'(level);
    p = per(l);
    exp_t = 1;
    exp_s = 1;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (!clear_n || l == 0 || (m_prev != 0 && l != m_prev)) begin
      m_e = 0;
    end else if (hold_n) begin
      m_e++;
      if (m_e == Q * p) begin
        exp_t = 0;
        m_e = 0;
      end else if (p >= 2 && m_e == Q * (p / 2)) begin
        exp_s = 0;
      end
    end
    if (!clear_n) m_pts = 0;
    else if (l != 0 && !move_n && m_pts < 255) m_pts++;
    m_prev = l;
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("timer_cycle", int'(timer_o), exp_t);
      chk("speed_cycle", int'(speed_o), exp_s);
      chk("points_cycle", int'(pts_o), m_pts);
    end
  end

  initial begin
    rst_n = 1'b1; clear_n = 1'b1; level = 2'd0; hold_n = 1'b1; move_n = 1'b1;
    model_reset();
    #1 rst_n = 1'b0;
    #1;
    chk("reset_timer", int'(timer_o), 1);
    chk("reset_speed", int'(speed_o), 1);
    chk("reset_points", int'(pts_o), 0);
    chk_en = 1'b1;
    repeat (3) step();
    rst_n = 1'b1;
    repeat (4) step();

    // Level 1: period 20 clocks, mid strobe 12 clocks before the end
    level = 2'd1;
    for (int k = 1; k <= 52; k++) begin
      step();
      if (k == 8 || k == 28) chk("lvl1_speed_strobe", int'(speed_o), 0);
      if (k == 20 || k == 40) chk("lvl1_timer_strobe", int'(timer_o), 0);
      if (k == 21) chk("lvl1_timer_one_cycle", int'(timer_o), 1);
    end

    // Switch to level 3 at period_cnt=3
    level = 2'd3;
    for (int j = 1; j <= 20; j++) begin
      step();
      if (j == 1) begin
        chk("switch_no_timer", int'(timer_o), 1);
        chk("switch_no_speed", int'(speed_o), 1);
      end
      if (j == 9 || j == 17) chk("lvl3_timer_strobe", int'(timer_o), 0);
      if (j == 5) chk("lvl3_speed_strobe", int'(speed_o), 0);
    end

    // Hold for 50 clocks at period_cnt=2 of level 1
    level = 2'd1;
    repeat (9) step();
    hold_n = 1'b0;
    lows = 0;
    repeat (50) begin
      step();
      if (!timer_o || !speed_o) lows++;
    end
    chk("hold_no_strobes", lows, 0);
    hold_n = 1'b1;
    for (int j = 1; j <= 12; j++) begin
      step();
      if (j == 11) chk("resume_not_early", int'(timer_o), 1);
      if (j == 12) chk("resume_timer_strobe", int'(timer_o), 0);
    end

    level = 2'd2;
    repeat (30) step();

    // Saturation and clear
    level = 2'd1;
    repeat (260) begin
      move_n = 1'b0; step();
      move_n = 1'b1; step();
    end
    chk("points_saturate", int'(pts_o), 255);
    move_n = 1'b0;
    repeat (3) step();
    move_n = 1'b1;
    chk("points_stay_255", int'(pts_o), 255);
    clear_n = 1'b0; move_n = 1'b0;
    step();
    clear_n = 1'b1; move_n = 1'b1;
    chk("clear_points", int'(pts_o), 0);

    // Move coincident with period end at points=31
    move_n = 1'b0;
    repeat (31) step();
    chk("points_held_31", int'(pts_o), 31);
    move_n = 1'b1;
    repeat (8) step();
    move_n = 1'b0;
    step();
    move_n = 1'b1;
    chk("coincide_points", int'(pts_o), 32);
    chk("coincide_timer", int'(timer_o), 0);

    // Async reset mid-period with points=40
    move_n = 1'b0;
    repeat (8) step();
    move_n = 1'b1;
    chk("points_40", int'(pts_o), 40);
    repeat (2) step();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_points", int'(pts_o), 0);
    chk("async_timer", int'(timer_o), 1);
    chk("async_speed", int'(speed_o), 1);
    level = 2'd0;
    step();
    rst_n = 1'b1;
    lows = 0;
    repeat (100) begin
      step();
      if (!timer_o || !speed_o) lows++;
    end
    chk("idle_no_strobes", lows, 0);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
